decimal_number_display: RTL
===========================

// Module: decimal_number_display
// PURPOSE
// - Multi-digit 7-segment driver: converts a WIDTH-bit unsigned or two's-complement value
//   into NUM_DIGITS segment patterns, one digit per cycle (repeated /10, %10).
// - Leading blanking, optional minus sign, overflow indication.
// - Outputs are double-buffered so the display never shows a partial conversion.
// - Sits between the arithmetic datapath and the physical display lamps.
// PARAMETERS
// - WIDTH       16  input value width in bits (>= 4)
// - NUM_DIGITS   5  display positions; digit 0 is rightmost
// - SIGNED       0  1: in_number is two's complement; minus sign occupies one position
// - SHOW_ZERO    1  1: value 0 shows "0" in digit 0; 0: value 0 shows all blank
// PORTS
// - clk             input   1               single clock, all state on rising edge
// - rst             input   1               synchronous, active-high reset
// - in_valid        input   1               request conversion of in_number
// - in_ready        output  1               block idle, can accept a request
// - in_number       input   WIDTH           value to display
// - done            output  1               one-cycle pulse when display registers updated
// - overflow        output  1               last committed value did not fit
// - segments        output  7*NUM_DIGITS    digit d at [7*d+6 : 7*d]; bit order per digit
//                                           {top_left, top, top_right, bottom_right, bottom, bottom_left, middle}
// BEHAVIOUR
// - Reset: state IDLE, in_ready=1, done=0, overflow=0, all segments=0 (all positions blank).
// - Handshake: request accepted on a cycle with in_valid && in_ready; in_number is
//   latched that edge; in_ready=0 from the next cycle until the cycle after done.
//   in_valid while busy is ignored (not queued).
// - FSM: IDLE -> (accept) CONVERT -> (NUM_DIGITS cycles) COMMIT -> IDLE.
//   - Accept edge: magnitude reg <= |in_number| computed in WIDTH+1 bits
//     (SIGNED; the most-negative value is handled exactly), neg <= sign bit, idx <= 0.
//   - CONVERT, each cycle: shadow[idx] <= rem % 10 if rem != 0, else EMPTY_DIGIT;
//     rem <= rem / 10; idx++.
//   - First EMPTY position after the magnitude gets MINUS_DIGIT if neg.
//   - Value 0: shadow[0] = 0 if SHOW_ZERO, else all EMPTY.
//   - Overflow: rem != 0 after NUM_DIGITS digits, or neg with no free position.
//     On overflow, every position shows MINUS_DIGIT (dashes) and overflow=1.
//   - COMMIT: segments <= decode(shadow), overflow updated, done=1 for exactly this cycle.
//   - in_ready=1 again the cycle after COMMIT.
// - Latency: accept at edge N -> done high in cycle N+NUM_DIGITS+1; new segments visible
//   that same cycle. Back-to-back throughput: one conversion per NUM_DIGITS+2 cycles.
// - Between commits, segments/overflow hold their previous values; no partial updates.
// - rst mid-conversion: aborts immediately, applies reset values, no done pulse.
// - Arithmetic: rem is WIDTH+1 bits unsigned; /10 and %10 are combinational on rem;
//   digit values are 4-bit.
// STRUCTURE
// - Shared package display_pkg:
//   - typedef Digit (4-bit)
//   - localparams EMPTY_DIGIT = 4'hF, MINUS_DIGIT = 4'hA
//   - typedef Segments (7-bit) with the bit order above
// - Sub-module digit_segment_decoder (Digit in, Segments out, combinational), instantiated
//   NUM_DIGITS times on the shadow array at commit:
//   - 0-9 give the standard glyphs
//   - MINUS_DIGIT gives middle only
//   - EMPTY_DIGIT gives all off
// - FSM, index counter, rem register and shadow array live in this module.
// TESTING (defaults unless stated)
// - Reset: after rst, segments == 0, in_ready == 1, overflow == 0, no done for 20 cycles
//   with in_valid=0.
// - Value 1234: done exactly 6 cycles after accept; digits 4,3,2,1 then blank in digit 4;
//   overflow=0.
// - Value 0: digit 0 shows "0", others blank. With SHOW_ZERO=0: all blank, done still pulses.
// - SIGNED=1, value 16'h8000: rem=32768 fills 5 digits, leaving no room for the minus sign,
//   so overflow=1 and all dashes. Repeat with NUM_DIGITS=6: shows "-32768", overflow=0.
// - SIGNED=1, value -7 (16'hFFF9): digit 0 = 7, digit 1 = minus, rest blank.
// - Busy handling: hold in_valid=1 and change in_number every cycle during a conversion.
//   Only the accepted value appears, and segments keep the old value until done.
//   Assert rst in the 3rd CONVERT cycle: no done pulse, segments cleared.

Source files
------------

// File: rtl/display_pkg.sv
// Shared digit/segment types and special digit codes for the decimal display path.
package display_pkg;

    typedef logic [3:0] Digit;

    // Bit order per digit: {top_left, top, top_right, bottom_right, bottom, bottom_left, middle}
    typedef logic [6:0] Segments;

    localparam Digit EMPTY_DIGIT = 4'hF;
    localparam Digit MINUS_DIGIT = 4'hA;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_t;

endpackage

// File: rtl/digit_segment_decoder.sv
// Combinational digit code to 7-segment glyph; no latency, no flow control.
module digit_segment_decoder
    import display_pkg::*;
(
    input  Digit    digit,
    output Segments segments
);

    always_comb begin
        segments = 7'b0000000;
        case (digit)
            4'd0:        segments = 7'b1111110;
            4'd1:        segments = 7'b0011000;
            4'd2:        segments = 7'b0110111;
            4'd3:        segments = 7'b0111101;
            4'd4:        segments = 7'b1011001;
            4'd5:        segments = 7'b1101101;
            4'd6:        segments = 7'b1101111;
            4'd7:        segments = 7'b0111000;
            4'd8:        segments = 7'b1111111;
            4'd9:        segments = 7'b1111101;
            MINUS_DIGIT: segments = 7'b0000001;
            default:     segments = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/decimal_number_display.sv
// Binary to multi-digit 7-segment converter, one digit per cycle, committed atomically.
// Done NUM_DIGITS+1 cycles after accept; requests arriving while busy are dropped.
module decimal_number_display
    import display_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int NUM_DIGITS = 5,
    parameter bit SIGNED     = 1'b0,
    parameter bit SHOW_ZERO  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_number,
    output logic                    done,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] segments
);

    localparam int RW   = WIDTH + 1;
    localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_t                  state, state_nxt;
    logic [RW-1:0]           rem, rem_div, mag_in;
    Digit                    rem_mod, cur_digit;
    logic [IDXW-1:0]         idx;
    logic                    neg, minus_done, cur_minus, last, ovf_nxt;
    Digit                    shadow     [NUM_DIGITS];
    Digit                    shadow_nxt [NUM_DIGITS];
    Digit                    show       [NUM_DIGITS];
    Segments                 glyph      [NUM_DIGITS];
    logic [7*NUM_DIGITS-1:0] seg_nxt;

    // Extra bit keeps the magnitude of the most-negative input exact.
    always_comb begin
        if (SIGNED && in_number[WIDTH-1])
            mag_in = -{in_number[WIDTH-1], in_number};
        else
            mag_in = {1'b0, in_number};
    end

    assign rem_div = rem / RW'(10);
    assign rem_mod = Digit'(rem % RW'(10));
    assign last    = (idx == IDXW'(NUM_DIGITS - 1));

    always_comb begin
        cur_minus = 1'b0;
        if (rem != '0)
            cur_digit = rem_mod;
        else if (neg && !minus_done) begin
            cur_digit = MINUS_DIGIT;
            cur_minus = 1'b1;
        end else if (idx == '0 && SHOW_ZERO)
            cur_digit = 4'd0;
        else
            cur_digit = EMPTY_DIGIT;
    end

    // Final digit is merged combinationally so the glyphs land on the same edge as COMMIT entry.
    assign ovf_nxt = (rem_div != '0) || (neg && !(minus_done || cur_minus));

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        assign shadow_nxt[d] = (idx == IDXW'(d)) ? cur_digit : shadow[d];
        assign show[d]       = ovf_nxt ? MINUS_DIGIT : shadow_nxt[d];
        digit_segment_decoder u_dec (
            .digit    (show[d]),
            .segments (glyph[d])
        );
        assign seg_nxt[7*d +: 7] = glyph[d];
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CONVERT;
            end
            CONVERT: begin
                if (last) state_nxt = COMMIT;
            end
            COMMIT: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            segments   <= '0;
            overflow   <= 1'b0;
            rem        <= '0;
            idx        <= '0;
            neg        <= 1'b0;
            minus_done <= 1'b0;
            for (int d = 0; d < NUM_DIGITS; d++) shadow[d] <= EMPTY_DIGIT;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                rem        <= mag_in;
                neg        <= SIGNED && in_number[WIDTH-1];
                idx        <= '0;
                minus_done <= 1'b0;
            end else if (state == CONVERT) begin
                for (int d = 0; d < NUM_DIGITS; d++) shadow[d] <= shadow_nxt[d];
                rem        <= rem_div;
                minus_done <= minus_done | cur_minus;
                idx        <= idx + IDXW'(1);
                if (last) begin
                    segments <= seg_nxt;
                    overflow <= ovf_nxt;
                end
            end
        end
    end

endmodule
